// File: rtl/pipeprefetch_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeprefetch_if
// Purpose  : Bundles the decode-side and instruction-memory-side signals of
//            the instruction prefetch queue.
// Signals  :
//   redirect     taken branch/jump, flush and refetch
//   redirect_pc  new fetch target (word aligned)
//   take         decode consumes the head entry this cycle
//   valid        head entry present
//   pc/pc4/inst  head instruction address, address + 4, instruction word
//   mreq/maddr   registered memory request and address
//   mack/mdata   memory completion and returned instruction word
// Modports : master = prefetch queue, slave = CPU decode stage + memory
// Revision : 1.0 - initial release
// ============================================================================
interface pipeprefetch_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        take;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] inst;
  logic        mreq;
  logic [31:0] maddr;
  logic        mack;
  logic [31:0] mdata;

  modport master (
    input  redirect, redirect_pc, take, mack, mdata,
    output valid, pc, pc4, inst, mreq, maddr
  );

  modport slave (
    output redirect, redirect_pc, take, mack, mdata,
    input  valid, pc, pc4, inst, mreq, maddr
  );
endinterface
`default_nettype wire

// File: rtl/pipeprefetch.sv
`default_nettype none
// ============================================================================
// Module   : pipeprefetch
// Purpose  : Instruction prefetch queue ahead of the IF/ID register. Fetches
//            from a variable-latency memory with a single outstanding
//            request, buffers up to DEPTH {pc, inst} entries and presents the
//            oldest one to decode. A redirect flushes the queue and restarts
//            fetch at the new target, dropping any stale in-flight response.
// Ports    :
//   clock  rising-edge clock
//   reset  synchronous active-high reset
//   bus    pipeprefetch_if.master (decode side + memory side)
// Params   : DEPTH (power of two, >= 2), RESET_PC (first fetch address)
// Revision : 1.0 - initial release
// ============================================================================
module pipeprefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clock,
  input  logic           reset,
  pipeprefetch_if.master bus
);

  localparam int            AW         = $clog2(DEPTH);
  localparam int            CW         = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // IDLE: no request outstanding; BUSY: waiting on a live request;
  // DROP: waiting on a request made stale by a redirect.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_mreq;
  logic          w_mreq_next;
  logic [31:0]   r_maddr;
  logic [31:0]   w_maddr_next;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];

  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_room;
  logic [31:0]   w_head_pc;

  // --------------------------------------------------------------------------
  // Queue bookkeeping
  // --------------------------------------------------------------------------
  assign w_valid = (r_count != '0);
  assign w_pop   = bus.take && w_valid;
  // Only a response to a live request is written; a redirect in the same
  // cycle wins over the write.
  assign w_push  = (r_state == S_BUSY) && bus.mack && !bus.redirect;

  always_comb begin
    w_count_next = r_count;
    if (bus.redirect) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  always_comb begin
    w_fetch_pc_next = r_fetch_pc;
    if (bus.redirect) begin
      w_fetch_pc_next = bus.redirect_pc;
    end else if (w_push) begin
      w_fetch_pc_next = r_maddr + 32'd4;
    end
  end

  // A new request is only launched while there is space for its response,
  // so an accepted mack can never overflow the queue.
  assign w_room = (w_count_next < FULL_COUNT);

  // --------------------------------------------------------------------------
  // Fetch state machine: next-state and registered request outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_mreq_next  = r_mreq;
    w_maddr_next = r_maddr;
    case (r_state)
      S_IDLE: begin
        if (w_room) begin
          w_state_next = S_BUSY;
          w_mreq_next  = 1'b1;
          w_maddr_next = w_fetch_pc_next;
        end
      end
      S_BUSY: begin
        if (bus.mack) begin
          // Redirect+mack clears the count, so w_room is always true there
          // and the next request goes straight to the redirect target.
          if (w_room) begin
            w_maddr_next = w_fetch_pc_next;
          end else begin
            w_state_next = S_IDLE;
            w_mreq_next  = 1'b0;
          end
        end else if (bus.redirect) begin
          // Request cannot be withdrawn: hold mreq/maddr until its mack.
          w_state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (bus.mack) begin
          w_state_next = S_BUSY;
          w_maddr_next = w_fetch_pc_next;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_mreq_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mreq     <= 1'b0;
      r_maddr    <= '0;
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_mreq     <= w_mreq_next;
      r_maddr    <= w_maddr_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_count    <= w_count_next;
      if (bus.redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
      end
    end
  end

  // Entry storage needs no reset: count gates every read of it.
  always_ff @(posedge clock) begin
    if (w_push && !reset) begin
      r_pc_mem[r_wr_ptr]   <= r_maddr;
      r_inst_mem[r_wr_ptr] <= bus.mdata;
    end
  end

  // --------------------------------------------------------------------------
  // Head outputs (zero when the queue is empty)
  // --------------------------------------------------------------------------
  assign w_head_pc = w_valid ? r_pc_mem[r_rd_ptr] : 32'h0;

  assign bus.valid = w_valid;
  assign bus.pc    = w_head_pc;
  assign bus.pc4   = w_valid ? (w_head_pc + 32'd4) : 32'h0;
  assign bus.inst  = w_valid ? r_inst_mem[r_rd_ptr] : 32'h0;
  assign bus.mreq  = r_mreq;
  assign bus.maddr = r_maddr;

endmodule
`default_nettype wire

// File: tb/tb_pipeprefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeprefetch
// Purpose  : Self-checking bench for pipeprefetch. A transaction-level model
//            (queue of fetched PCs plus one outstanding-request record) gives
//            the expected head and request outputs; a behavioural memory
//            answers requests after a programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeprefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clock = 1'b0;
  logic reset;

  pipeprefetch_if bus ();

  pipeprefetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;

  // Memory model state
  bit mem_busy;
  int mem_age;
  int mem_lat;
  int lat_lo;
  int lat_hi;

  // Reference model state
  logic [31:0] mq[$];
  bit          m_out;
  bit          m_stale;
  logic [31:0] m_addr;
  logic [31:0] m_fetch;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // {valid, pc, pc4, inst, mreq, maddr-if-mreq}
  function automatic logic [129:0] exp_vec();
    logic        v;
    logic [31:0] p;
    v = (mq.size() != 0);
    p = 32'h0;
    if (v) p = mq[0];
    return {v, p, (v ? p + 32'd4 : 32'h0), (v ? inst_of(p) : 32'h0),
            m_out, (m_out ? m_addr : 32'h0)};
  endfunction

  function automatic logic [129:0] dut_vec();
    return {bus.valid, bus.pc, bus.pc4, bus.inst, bus.mreq,
            (bus.mreq ? bus.maddr : 32'h0)};
  endfunction

  // Behaviour of one clock edge, from the queue's rules.
  task automatic model_step(input logic rst, input logic rd, input logic [31:0] rpc,
                            input logic tk, input logic mk);
    bit done;
    if (rst) begin
      mq.delete();
      m_out   = 0;
      m_stale = 0;
      m_addr  = 32'h0;
      m_fetch = RESET_PC;
    end else begin
      done = m_out && mk;
      if (tk && mq.size() > 0) void'(mq.pop_front());
      if (done && !m_stale && !rd) begin
        mq.push_back(m_addr);
        m_fetch = m_addr + 32'd4;
      end
      if (rd) begin
        mq.delete();
        m_fetch = rpc;
      end
      if (m_out && !done) begin
        if (rd) m_stale = 1;
      end else if (mq.size() < DEPTH) begin
        m_out   = 1;
        m_addr  = m_fetch;
        m_stale = 0;
      end else begin
        m_out = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, answer memory, clock, and advance the model.
  task automatic cycle(input logic rst, input logic rd, input logic [31:0] rpc,
                       input logic tk);
    reset           = rst;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.take        = tk;
    if (bus.mreq === 1'b1 && !rst) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_age  = 0;
        mem_lat  = int'($urandom_range(lat_hi, lat_lo));
      end
      bus.mack = (mem_age >= mem_lat);
    end else begin
      bus.mack = 1'b0;
    end
    bus.mdata = bus.mack ? inst_of(bus.maddr) : 32'hDEAD_BEEF;
    @(posedge clock);
    model_step(rst, rd, rpc, tk, bus.mack);
    if (rst || bus.mack) mem_busy = 0;
    else if (mem_busy) mem_age++;
    #1;
  endtask

  task automatic do_reset(input int lo, input int hi);
    lat_lo = lo;
    lat_hi = hi;
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset(0, 0);
    n_checks++;
    if (bus.valid !== 1'b0) begin
      n_fails++; $display("FAIL reset_valid: got %b expected 0", bus.valid);
    end
    n_checks++;
    if ({bus.pc, bus.pc4, bus.inst} !== 96'h0) begin
      n_fails++; $display("FAIL reset_head: got %h %h %h expected zeros", bus.pc, bus.pc4, bus.inst);
    end
    n_checks++;
    if (bus.mreq !== 1'b0 || bus.maddr !== 32'h0) begin
      n_fails++; $display("FAIL reset_req: got mreq=%b maddr=%h expected 0/0", bus.mreq, bus.maddr);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (bus.mreq !== 1'b1 || bus.maddr !== RESET_PC) begin
      n_fails++; $display("FAIL first_req: got mreq=%b maddr=%h expected 1/%h", bus.mreq, bus.maddr, RESET_PC);
    end
  endtask

  task automatic test_fill();
    logic [31:0] seen[$];
    bit          ok;
    do_reset(0, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fails++; $display("FAIL fill_model: got %h expected %h", dut_vec(), exp_vec());
      end
      if (bus.mreq === 1'b1) seen.push_back(bus.maddr);
    end
    ok = (seen.size() == 4);
    for (int i = 0; i < seen.size() && ok; i++) ok = (seen[i] == RESET_PC + 32'(4 * i));
    n_checks++;
    if (!ok) begin
      n_fails++; $display("FAIL fill_addrs: got %0d requests expected 4 at 0,4,8,12", seen.size());
    end
    n_checks++;
    if (bus.mreq !== 1'b0 || bus.valid !== 1'b1) begin
      n_fails++; $display("FAIL fill_full: got mreq=%b valid=%b expected 0/1", bus.mreq, bus.valid);
    end
    n_checks++;
    if (bus.pc !== 32'h0 || bus.pc4 !== 32'h4 || bus.inst !== inst_of(32'h0)) begin
      n_fails++; $display("FAIL fill_head: got %h %h %h expected 0 4 %h", bus.pc, bus.pc4, bus.inst, inst_of(32'h0));
    end
  endtask

  task automatic test_stream();
    do_reset(0, 0);
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fails++; $display("FAIL stream_model: cycle %0d got %h expected %h", k, dut_vec(), exp_vec());
      end
      if (k >= 2) begin
        n_checks++;
        if (bus.valid !== 1'b1 || bus.pc !== RESET_PC + 32'(4 * (k - 2))) begin
          n_fails++; $display("FAIL stream_pc: cycle %0d got valid=%b pc=%h expected 1/%h", k, bus.valid, bus.pc, RESET_PC + 32'(4 * (k - 2)));
        end
      end
    end
  endtask

  task automatic test_redirect_pending();
    bit          found;
    bit          got_addr;
    bit          got_pc;
    logic [31:0] new_addr;
    logic [31:0] first_pc;
    do_reset(3, 3);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      if (bus.mreq === 1'b1 && bus.maddr === 32'h8) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fails++; $display("FAIL rp_reach: got no request for 8 expected one within 40 cycles");
    end
    cycle(1'b0, 1'b1, 32'h100, 1'b0);
    n_checks++;
    if (bus.valid !== 1'b0 || bus.mreq !== 1'b1 || bus.maddr !== 32'h8) begin
      n_fails++; $display("FAIL rp_hold: got valid=%b mreq=%b maddr=%h expected 0/1/8", bus.valid, bus.mreq, bus.maddr);
    end
    got_addr = 0;
    got_pc   = 0;
    new_addr = 32'h0;
    first_pc = 32'h0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fails++; $display("FAIL rp_model: got %h expected %h", dut_vec(), exp_vec());
      end
      if (!got_addr && bus.mreq === 1'b1 && bus.maddr !== 32'h8) begin
        got_addr = 1; new_addr = bus.maddr;
      end
      if (!got_pc && bus.valid === 1'b1) begin
        got_pc = 1; first_pc = bus.pc;
      end
    end
    n_checks++;
    if (!got_addr || new_addr !== 32'h100) begin
      n_fails++; $display("FAIL rp_target: got maddr=%h expected 00000100", new_addr);
    end
    n_checks++;
    if (!got_pc || first_pc !== 32'h100) begin
      n_fails++; $display("FAIL rp_first_pc: got pc=%h expected 00000100", first_pc);
    end
  endtask

  task automatic test_redirect_mack_take();
    do_reset(0, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (bus.valid !== 1'b1 || bus.pc !== 32'h0 || bus.mreq !== 1'b1 || mq.size() != 2) begin
      n_fails++; $display("FAIL rmt_setup: got valid=%b pc=%h mreq=%b expected 1/0/1 with two entries", bus.valid, bus.pc, bus.mreq);
    end
    cycle(1'b0, 1'b1, 32'h200, 1'b1);
    n_checks++;
    if (bus.valid !== 1'b0 || bus.mreq !== 1'b1 || bus.maddr !== 32'h200) begin
      n_fails++; $display("FAIL rmt_flush: got valid=%b mreq=%b maddr=%h expected 0/1/200", bus.valid, bus.mreq, bus.maddr);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (bus.valid !== 1'b1 || bus.pc !== 32'h200 || bus.inst !== inst_of(32'h200)) begin
      n_fails++; $display("FAIL rmt_target: got valid=%b pc=%h inst=%h expected 1/200/%h", bus.valid, bus.pc, bus.inst, inst_of(32'h200));
    end
  endtask

  task automatic test_full_wrap();
    int nreq;
    do_reset(0, 0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (bus.mreq !== 1'b0 || bus.valid !== 1'b1) begin
      n_fails++; $display("FAIL full_idle: got mreq=%b valid=%b expected 0/1", bus.mreq, bus.valid);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    nreq = (bus.mreq === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      if (bus.mreq === 1'b1) nreq++;
    end
    n_checks++;
    if (nreq != 1 || bus.mreq !== 1'b0) begin
      n_fails++; $display("FAIL full_one_req: got %0d requests expected 1", nreq);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (bus.valid !== 1'b1 || bus.pc !== RESET_PC + 32'(4 + 4 * i)) begin
        n_fails++; $display("FAIL full_order: take %0d got valid=%b pc=%h expected 1/%h", i, bus.valid, bus.pc, RESET_PC + 32'(4 + 4 * i));
      end
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
    end
  endtask

  task automatic test_reset_busy();
    bit found;
    do_reset(2, 2);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      if (mq.size() == 3 && bus.mreq === 1'b1) found = 1;
    end
    n_checks++;
    if (!found || bus.valid !== 1'b1) begin
      n_fails++; $display("FAIL rb_reach: got found=%b valid=%b expected 1/1", found, bus.valid);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (bus.valid !== 1'b0 || bus.mreq !== 1'b0) begin
      n_fails++; $display("FAIL rb_drop: got valid=%b mreq=%b expected 0/0", bus.valid, bus.mreq);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (bus.mreq !== 1'b1 || bus.maddr !== RESET_PC) begin
      n_fails++; $display("FAIL rb_restart: got mreq=%b maddr=%h expected 1/%h", bus.mreq, bus.maddr, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic        rd;
    logic        tk;
    logic        rst;
    logic [31:0] rpc;
    do_reset(0, 3);
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(127, 0) == 0);
      rd  = ($urandom_range(15, 0) == 0);
      tk  = ($urandom_range(1, 0) == 1);
      rpc = $urandom & 32'h0000_0FFC;
      cycle(rst, rd, rpc, tk);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fails++; $display("FAIL random_model: iter %0d got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.take        = 1'b0;
    bus.mack        = 1'b0;
    bus.mdata       = 32'h0;
    mem_busy        = 0;
    mem_age         = 0;
    mem_lat         = 0;
    lat_lo          = 0;
    lat_hi          = 0;
    m_out           = 0;
    m_stale         = 0;
    m_addr          = 32'h0;
    m_fetch         = RESET_PC;
    #2;
    test_reset();
    test_fill();
    test_stream();
    test_redirect_pending();
    test_redirect_mack_take();
    test_full_wrap();
    test_reset_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
